// File: rtl/texture_mem_responder.sv
// Line-fill / write-back responder for the texture cache. Each 64-bit line
// maps to four 16-bit SRAM halfwords; data returns to the cache as two 32-bit beats.
module texture_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] mem_wrdata,
  output logic        mem_ready,
  output logic [31:0] mem_rddata,
  output logic        busy,
  output logic [21:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] A = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [1:0]  k_q;
  logic [3:0]  wt_q;
  logic [19:0] line_q;
  logic [63:0] wr_q;
  logic [15:0] lo_q;
  logic [1:0]  k_d;

  assign k_d = k_q + 2'd1;

  function automatic logic [15:0] wr_hw(input logic [63:0] d, input logic [1:0] k);
    return d[{k, 4'b0000} +: 16];
  endfunction

  // All outputs are registered; every transition sets up the next cycle's bus state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      wt_q       <= '0;
      line_q     <= '0;
      wr_q       <= '0;
      lo_q       <= '0;
      mem_ready  <= 1'b0;
      mem_rddata <= '0;
      busy       <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      mem_ready <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_write) begin
            state_q    <= WR_SETUP;
            line_q     <= mem_addr;
            wr_q       <= mem_wrdata;
            k_q        <= '0;
            sram_addr  <= {mem_addr, 2'b00};
            sram_dq_o  <= mem_wrdata[15:0];
            sram_dq_oe <= 1'b1;
            sram_ce_n  <= 1'b0;
            busy       <= 1'b1;
          end else if (mem_read) begin
            state_q   <= RD_ACC;
            line_q    <= mem_addr;
            k_q       <= '0;
            wt_q      <= '0;
            sram_addr <= {mem_addr, 2'b00};
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RD_ACC: begin
          if (wt_q == A) begin
            wt_q <= '0;
            // Odd halfwords complete a beat; even ones are parked until then.
            if (!k_q[0]) begin
              lo_q <= sram_dq_i;
            end else begin
              mem_ready  <= 1'b1;
              mem_rddata <= {sram_dq_i, lo_q};
            end
            if (k_q == 2'd3) begin
              state_q   <= DONE;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
            end else begin
              k_q       <= k_d;
              sram_addr <= {line_q, k_d};
            end
          end else begin
            wt_q <= wt_q + 4'd1;
          end
        end
        WR_SETUP: begin
          state_q   <= WR_STROBE;
          sram_we_n <= 1'b0;
          wt_q      <= 4'd1;
        end
        WR_STROBE: begin
          if (wt_q == A) begin
            state_q   <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            wt_q <= wt_q + 4'd1;
          end
        end
        WR_HOLD: begin
          if (k_q[0]) mem_ready <= 1'b1;
          if (k_q == 2'd3) begin
            state_q    <= DONE;
            sram_ce_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else begin
            state_q   <= WR_SETUP;
            k_q       <= k_d;
            sram_addr <= {line_q, k_d};
            sram_dq_o <= wr_hw(wr_q, k_d);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_texture_mem_responder.sv
// Directed bench for texture_mem_responder: vector table plus hand-written
// sequences for read/write collision, mid-access reset and back-to-back reads.
module tb_texture_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [19:0] mem_addr;
  logic        mem_read, mem_write;
  logic [63:0] mem_wrdata;
  logic        mem_ready, busy;
  logic [31:0] mem_rddata;
  logic [21:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic [19:0] addr1;
  logic        rd1;
  logic        rdy1, busy1;
  logic [31:0] rddata1;
  logic [21:0] saddr1;
  logic [15:0] dqo1, dqi1;
  logic        dqoe1, ce1_n, oe1_n, we1_n;

  texture_mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wrdata(mem_wrdata), .mem_ready(mem_ready),
    .mem_rddata(mem_rddata), .busy(busy), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  texture_mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_read(rd1),
    .mem_write(1'b0), .mem_wrdata(64'h0), .mem_ready(rdy1),
    .mem_rddata(rddata1), .busy(busy1), .sram_addr(saddr1),
    .sram_dq_o(dqo1), .sram_dq_i(dqi1), .sram_dq_oe(dqoe1),
    .sram_ce_n(ce1_n), .sram_oe_n(oe1_n), .sram_we_n(we1_n)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Async SRAM models and bus-invariant monitors, evaluated mid-cycle.
  logic [15:0] smem [logic [21:0]];
  logic [15:0] mem1 [4];
  int inv_err = 0, inv1_err = 0;
  logic prev_rdy = 1'b0, prev_rdy1 = 1'b0;

  always @(negedge clk) begin
    if (!sram_oe_n && !sram_we_n) inv_err++;
    if (sram_dq_oe && !sram_oe_n) inv_err++;
    if (prev_rdy && mem_ready) inv_err++;
    prev_rdy = mem_ready;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) smem[sram_addr] = sram_dq_o;
    if (!sram_ce_n && !sram_oe_n && smem.exists(sram_addr)) sram_dq_i = smem[sram_addr];
    else sram_dq_i = 16'h0;
  end

  always @(negedge clk) begin
    if (!oe1_n && !we1_n) inv1_err++;
    if (dqoe1 && !oe1_n) inv1_err++;
    if (prev_rdy1 && rdy1) inv1_err++;
    prev_rdy1 = rdy1;
    if (!ce1_n && !oe1_n && saddr1[21:2] == 20'h00012) dqi1 = mem1[saddr1[1:0]];
    else dqi1 = 16'h0;
  end

  typedef struct {
    int rdy0, rdy1, nrdy, busy_end, we, dqoe, oel, first_oe;
    logic [31:0] d0, d1;
  } rec_t;

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [63:0] wd;
    int          rdy0, rdy1, busy_end, we, dqoe, oel;
    logic [31:0] d0, d1;
  } vec_t;

  // Inputs must already be driven; the next rising edge is cycle 0.
  task automatic observe(input bit hold_rd, output rec_t r);
    r = '{default: 0};
    r.busy_end = -1;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mem_write = 1'b0;
        mem_read  = hold_rd;
      end
      if (mem_ready) begin
        r.nrdy++;
        if (r.nrdy == 1) begin r.rdy0 = c; r.d0 = mem_rddata; end
        if (r.nrdy == 2) begin r.rdy1 = c; r.d1 = mem_rddata; end
      end
      if (!sram_we_n) r.we++;
      if (sram_dq_oe) r.dqoe++;
      if (!sram_oe_n) begin
        r.oel++;
        if (r.first_oe == 0) r.first_oe = c;
      end
      if (!busy) begin
        r.busy_end = c;
        break;
      end
    end
  endtask

  vec_t vecs[5];
  rec_t r;
  int   nr;
  int   n1;
  int   cyc1[6];
  logic [31:0] dat1[6];
  int   exp_c1[6] = '{5, 9, 15, 19, 25, 29};
  logic [15:0] exp_hw[4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

  initial begin
    vecs[0] = '{0, 20'h00012, 64'h0, 7, 13, 14, 0, 0, 12, 32'h22221111, 32'h44443333};
    vecs[1] = '{1, 20'hFFFFF, 64'hDDDDCCCCBBBBAAAA, 9, 17, 18, 8, 16, 0, 32'h44443333, 32'h44443333};
    vecs[2] = '{0, 20'hFFFFF, 64'h0, 7, 13, 14, 0, 0, 12, 32'hBBBBAAAA, 32'hDDDDCCCC};
    vecs[3] = '{1, 20'h00345, 64'h0123456789ABCDEF, 9, 17, 18, 8, 16, 0, 32'hDDDDCCCC, 32'hDDDDCCCC};
    vecs[4] = '{0, 20'h00345, 64'h0, 7, 13, 14, 0, 0, 12, 32'h89ABCDEF, 32'h01234567};

    smem[22'h48] = 16'h1111;
    smem[22'h49] = 16'h2222;
    smem[22'h4A] = 16'h3333;
    smem[22'h4B] = 16'h4444;
    mem1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wrdata = '0;
    rd1 = 1'b0; addr1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({mem_ready, mem_rddata, busy, sram_addr, sram_dq_o, sram_dq_oe,
             sram_ce_n, sram_oe_n, sram_we_n}),
        64'({1'b0, 32'h0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1}));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mem_addr   = vecs[i].addr;
      mem_wrdata = vecs[i].wd;
      mem_write  = vecs[i].wr;
      mem_read   = !vecs[i].wr;
      observe(1'b0, r);
      chk($sformatf("v%0d_nrdy", i), 64'(r.nrdy), 64'd2);
      chk($sformatf("v%0d_rdy0_cycle", i), 64'(r.rdy0), 64'(vecs[i].rdy0));
      chk($sformatf("v%0d_rdy1_cycle", i), 64'(r.rdy1), 64'(vecs[i].rdy1));
      chk($sformatf("v%0d_busy_end", i), 64'(r.busy_end), 64'(vecs[i].busy_end));
      chk($sformatf("v%0d_beat0", i), 64'(r.d0), 64'(vecs[i].d0));
      chk($sformatf("v%0d_beat1", i), 64'(r.d1), 64'(vecs[i].d1));
      chk($sformatf("v%0d_we_low_cycles", i), 64'(r.we), 64'(vecs[i].we));
      chk($sformatf("v%0d_dq_oe_cycles", i), 64'(r.dqoe), 64'(vecs[i].dqoe));
      chk($sformatf("v%0d_oe_low_cycles", i), 64'(r.oel), 64'(vecs[i].oel));
      @(negedge clk);
    end

    for (int k = 0; k < 4; k++)
      chk($sformatf("sram_top_hw%0d", k), 64'(smem[22'h3FFFFC + 22'(k)]), 64'(exp_hw[k]));

    // Read and write together, read held: write wins, read follows after DONE.
    mem_addr = 20'h00777; mem_wrdata = 64'h5555666677778888;
    mem_write = 1'b1; mem_read = 1'b1;
    observe(1'b1, r);
    chk("coll_rdy0_cycle", 64'(r.rdy0), 64'd9);
    chk("coll_rdy1_cycle", 64'(r.rdy1), 64'd17);
    chk("coll_busy_end", 64'(r.busy_end), 64'd18);
    chk("coll_no_read_access", 64'(r.oel), 64'd0);
    chk("coll_rddata_kept", 64'(r.d1), 64'h01234567);
    observe(1'b0, r);
    chk("coll_read_first_oe", 64'(r.first_oe), 64'd1);
    chk("coll_read_beat0", 64'(r.d0), 64'h77778888);
    chk("coll_read_beat1", 64'(r.d1), 64'h55556666);
    chk("coll_read_rdy1_cycle", 64'(r.rdy1), 64'd13);
    @(negedge clk);

    // Reset during cycle 5 of a read.
    mem_addr = 20'h00012; mem_read = 1'b1;
    nr = 0;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) mem_read = 1'b0;
      if (c == 5) rst = 1'b1;
      if (mem_ready) nr++;
    end
    @(negedge clk);
    if (mem_ready) nr++;
    chk("rst_no_ready", 64'(nr), 64'd0);
    chk("rst_bus_idle", 64'({busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}),
        64'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0}));
    rst = 1'b0; mem_read = 1'b1; mem_addr = 20'h00012;
    observe(1'b0, r);
    chk("rst_after_nrdy", 64'(r.nrdy), 64'd2);
    chk("rst_after_rdy0", 64'(r.rdy0), 64'd7);
    chk("rst_after_beat0", 64'(r.d0), 64'h22221111);
    chk("rst_after_beat1", 64'(r.d1), 64'h44443333);
    @(negedge clk);

    // WAIT_CYCLES=1, read held high so each request re-issues once busy falls.
    rd1 = 1'b1; addr1 = 20'h00012;
    n1 = 0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 30) rd1 = 1'b0;
      if (rdy1) begin
        if (n1 < 6) begin cyc1[n1] = c; dat1[n1] = rddata1; end
        n1++;
      end
    end
    chk("a1_beat_count", 64'(n1), 64'd6);
    for (int i = 0; i < 6 && i < n1; i++) begin
      chk($sformatf("a1_beat%0d_cycle", i), 64'(cyc1[i]), 64'(exp_c1[i]));
      chk($sformatf("a1_beat%0d_data", i), 64'(dat1[i]),
          (i % 2 == 0) ? 64'h22221111 : 64'h44443333);
    end
    chk("a1_idle_after", 64'(busy1), 64'd0);

    chk("invariants_a2", 64'(inv_err), 64'd0);
    chk("invariants_a1", 64'(inv1_err), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
